// File: rtl/echo_pkg.sv
// Shared definitions for the echo delay line.
//   DATA_W : sample width (signed two's complement)
//   ADDR_W : sample buffer address width (depth = 2**ADDR_W)
//   GAIN_W : unsigned Q0.8 echo gain width
//   state_t: priming state of the echo path
package echo_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int GAIN_W = 8;

  // The fill count saturates one below the buffer depth, so it fits in ADDR_W bits.
  localparam logic [ADDR_W-1:0] FILL_MAX = '1;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/echo_sample_ram.sv
// Simple dual-port sample buffer: one write port and one registered read port.
// Read data appears one cycle after the read address is presented with re high.
//   clk     : clock
//   we      : write enable; wr_data is stored at wr_addr
//   wr_addr : write address
//   wr_data : write data
//   re      : read enable; rd_addr is sampled this cycle
//   rd_addr : read address
//   rd_data : registered read data
module echo_sample_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array and its read register take no reset, so the tools can map
  // them onto block RAM; a reset would force a flop-based implementation.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/echo_delay_line.sv
// Echo delay line: buffers the incoming sample stream and returns each sample
// delay_len accepts later, scaled by a Q0.8 gain, two cycles after the accept.
// While the buffer does not yet hold delay_len samples the echo is forced to 0.
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   flush       : synchronous clear of pointer, fill count and state; drops
//                 any accept in the same cycle and kills in-flight echoes
//   in_valid    : in_sample is accepted this cycle
//   in_sample   : signed input sample
//   delay_len   : echo delay in samples (0 behaves as 1)
//   gain        : echo gain, Q0.8 unsigned
//   echo_valid  : echo_sample is valid this cycle
//   echo_sample : signed delayed, scaled sample
//   primed      : buffer holds enough history for the current delay
module echo_delay_line
  import echo_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic        [ADDR_W-1:0] delay_len,
  input  logic        [GAIN_W-1:0] gain,
  output logic                     echo_valid,
  output logic signed [DATA_W-1:0] echo_sample,
  output logic                     primed
);

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   fill_cnt;

  logic                accept;
  logic [ADDR_W-1:0]   eff_delay;
  logic [ADDR_W-1:0]   rd_addr;
  logic                enough;

  // Stage 1 side-band that travels alongside the RAM read.
  logic                s1_valid;
  logic                s1_run;
  logic [GAIN_W-1:0]   s1_gain;
  logic [DATA_W-1:0]   rd_data;

  logic signed [DATA_W+GAIN_W-1:0] wide_data;
  logic signed [DATA_W+GAIN_W-1:0] wide_gain;
  logic signed [DATA_W+GAIN_W-1:0] product;
  logic signed [DATA_W-1:0]        scaled;

  assign accept    = in_valid & ~flush;
  assign eff_delay = (delay_len == '0) ? ADDR_W'(1) : delay_len;
  // Natural ADDR_W-bit wrap gives the circular read address.
  assign rd_addr   = wr_ptr - eff_delay;
  // Decided on the fill count before this accept is counted, so the first
  // non-zero echo belongs to input sample index d.
  assign enough    = (fill_cnt >= eff_delay);

  echo_sample_ram #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .wr_addr (wr_ptr),
    .wr_data (in_sample),
    .re      (accept),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // |sample * gain| < 2**23, so a DATA_W+GAIN_W signed product cannot overflow.
  // The gain is zero-extended so it always acts as a non-negative factor.
  assign wide_data = {{GAIN_W{rd_data[DATA_W-1]}}, rd_data};
  assign wide_gain = {{DATA_W{1'b0}}, s1_gain};
  assign product   = wide_data * wide_gain;
  // Arithmetic shift floors toward -inf; the result always fits in DATA_W.
  assign scaled    = DATA_W'(product >>> GAIN_W);

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the values from before the edge, whatever the order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= PRIME;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      s1_valid    <= 1'b0;
      s1_run      <= 1'b0;
      s1_gain     <= '0;
      echo_valid  <= 1'b0;
      echo_sample <= '0;
    end else if (flush) begin
      state      <= PRIME;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      s1_valid   <= 1'b0;
      echo_valid <= 1'b0;
    end else begin
      s1_valid   <= accept;
      echo_valid <= s1_valid;

      if (accept) begin
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        fill_cnt <= (fill_cnt == FILL_MAX) ? fill_cnt : fill_cnt + ADDR_W'(1);
        s1_run   <= enough;
        s1_gain  <= gain;
        case (state)
          PRIME:   if (enough)  state <= RUN;
          RUN:     if (!enough) state <= PRIME;
          default: state <= PRIME;
        endcase
      end

      if (s1_valid) begin
        echo_sample <= s1_run ? scaled : '0;
      end
    end
  end

  assign primed = (state == RUN);

endmodule

// File: tb/tb_echo_delay_line.sv
// Directed self-checking bench for echo_delay_line. Each accept pushes its
// hand-computed echo and due cycle; a negedge monitor matches every echo_valid.
module tb_echo_delay_line;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int GAIN_W = 8;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     flush = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_sample = '0;
  logic        [ADDR_W-1:0] delay_len = '0;
  logic        [GAIN_W-1:0] gain = '0;
  logic                     echo_valid;
  logic signed [DATA_W-1:0] echo_sample;
  logic                     primed;

  echo_delay_line dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_sample   (in_sample),
    .delay_len   (delay_len),
    .gain        (gain),
    .echo_valid  (echo_valid),
    .echo_sample (echo_sample),
    .primed      (primed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  typedef struct {
    int due;
    int val;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Every echo_valid must match the oldest outstanding accept.
  always @(negedge clk) begin
    if (echo_valid) begin
      if (q.size() == 0) begin
        check("stray_valid", int'(echo_valid), 0);
      end else begin
        e = q.pop_front();
        check("latency", cyc, e.due);
        check("echo", int'(echo_sample), e.val);
      end
    end
  end

  task automatic accept(input int s, input int dly, input int g, input int exp_echo);
    exp_t n;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_sample = DATA_W'(s);
    delay_len = ADDR_W'(dly);
    gain      = GAIN_W'(g);
    n.due = cyc + 2;
    n.val = exp_echo;
    q.push_back(n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Flush (optionally together with an accept that must be dropped), then
  // confirm echo_valid stays low for the two following cycles.
  task automatic flush_cycle(input bit with_valid);
    @(posedge clk);
    #1;
    flush     = 1'b1;
    in_valid  = with_valid;
    in_sample = DATA_W'(777);
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_primed", int'(primed), 0);
    @(negedge clk);
    check("flush_kill1", int'(echo_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("flush_kill2", int'(echo_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    check("rst_valid", int'(echo_valid), 0);
    check("rst_sample", int'(echo_sample), 0);
    check("rst_primed", int'(primed), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Five accepts of 100, d=3, gain 255: 0,0,0,99,99.
    for (int k = 0; k < 5; k++) begin
      accept(100, 3, 255, (k >= 3) ? 99 : 0);
      if (k == 3) check("prime_before", int'(primed), 0);
      if (k == 4) check("prime_after", int'(primed), 1);
    end
    idle(4);

    // Ramp across the write-pointer wrap: d=1000, gain 128.
    flush_cycle(1'b0);
    for (int k = 0; k < 1200; k++) begin
      accept(k, 1000, 128, (k >= 1000) ? (k - 1000) / 2 : 0);
    end
    idle(4);
    check("ramp_primed", int'(primed), 1);

    // Negative input floors toward -inf: -3*128/256 = -1.5 -> -2.
    flush_cycle(1'b0);
    accept(-3, 1, 128, 0);
    accept(-3, 1, 128, -2);
    idle(4);

    // delay_len 0 acts as 1; gain 0 gives 0 while running.
    flush_cycle(1'b0);
    accept(5, 0, 255, 0);
    accept(7, 0, 255, 4);    // 5*255 = 1275 -> 4
    accept(9, 0, 255, 6);    // 7*255 = 1785 -> 6
    accept(11, 0, 0, 0);     // gain 0
    accept(13, 1, 255, 10);  // 11*255 = 2805 -> 10
    idle(4);

    // Raise delay from 4 to 20 with 10 samples stored. Sample 256*k with
    // gain 255 echoes exactly 255*k.
    flush_cycle(1'b0);
    for (int k = 0; k < 30; k++) begin
      int d;
      d = (k < 10) ? 4 : 20;
      accept(256 * k, d, 255, (k >= d) ? 255 * (k - d) : 0);
      if (k == 10) check("run_before_raise", int'(primed), 1);
      if (k == 11) check("drop_after_raise", int'(primed), 0);
      if (k == 20) check("still_prime", int'(primed), 0);
      if (k == 21) check("reprimed", int'(primed), 1);
    end

    // Mid-stream flush with a simultaneous accept, then refill with d=3.
    flush_cycle(1'b1);
    for (int k = 0; k < 6; k++) begin
      accept(256 * k, 3, 255, (k >= 3) ? 255 * (k - 3) : 0);
      if (k == 3) check("refill_prime0", int'(primed), 0);
      if (k == 4) check("refill_prime1", int'(primed), 1);
    end

    // Reset pulse during back-to-back traffic.
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    q.delete();
    #1;
    check("arst_valid", int'(echo_valid), 0);
    check("arst_sample", int'(echo_sample), 0);
    check("arst_primed", int'(primed), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", int'(echo_valid), 0);
    end
    for (int k = 0; k < 5; k++) begin
      accept(256 * k, 3, 255, (k >= 3) ? 255 * (k - 3) : 0);
    end
    idle(5);

    check("drain", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
